// File: rtl/dice_pkg.sv
// Shared definitions for the dice capture path: face limits, throw width and FSM states.
package dice_pkg;

  localparam int          THROW_W  = 3;
  localparam logic [2:0]  FACE_MIN = 3'd1;
  localparam logic [2:0]  FACE_MAX = 3'd6;

  typedef enum logic {
    IDLE    = 1'b0,
    ROLLING = 1'b1
  } cap_state_e;

  function automatic logic face_legal(input logic [THROW_W-1:0] face);
    return (face >= FACE_MIN) && (face <= FACE_MAX);
  endfunction

endpackage

// File: rtl/dice_face_tally.sv
// Six saturating per-face acceptance counters with a combinational read mux.
module dice_face_tally
  import dice_pkg::*;
#(
  parameter int TALLY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic [THROW_W-1:0] face,
  input  logic [THROW_W-1:0] sel,
  output logic [TALLY_W-1:0] count
);

  logic [TALLY_W-1:0] cnt_q [6];
  logic [TALLY_W-1:0] cnt_d [6];

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc && (face == THROW_W'(i + 1)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + TALLY_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end

  // Selects outside 1..6 fall through to zero.
  always_comb begin
    count = '0;
    for (int i = 0; i < 6; i++) begin
      if (sel == THROW_W'(i + 1)) count = cnt_q[i];
    end
  end

endmodule

// File: rtl/dice_capture.sv
// Detects dice roll releases, validates the face and offers it on a valid/ready output.
// Optional per-face tallies are built when DICE_TALLY_EN is defined.
//
//   state   | meaning
//   IDLE    | button low, waiting for a press
//   ROLLING | button held, counting press cycles up to MIN_PRESS
module dice_capture
  import dice_pkg::*;
#(
  parameter int MIN_PRESS = 4,
  parameter int TALLY_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button,
  input  logic [THROW_W-1:0] throw,
  output logic [THROW_W-1:0] result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               illegal,
  output logic               short_press,
  output logic               overrun,
  input  logic [THROW_W-1:0] tally_sel,
  output logic [TALLY_W-1:0] tally_count
);

  localparam logic [7:0] PRESS_MAX = 8'(MIN_PRESS);

  cap_state_e         state_q, state_d;
  logic [7:0]         press_q, press_d;
  logic [THROW_W-1:0] result_q, result_d;
  logic               valid_q, valid_d;
  logic               illegal_q, illegal_d;
  logic               short_q, short_d;
  logic               overrun_q, overrun_d;
  logic               tally_inc;

  always_comb begin
    state_d   = state_q;
    press_d   = press_q;
    result_d  = result_q;
    valid_d   = valid_q;
    illegal_d = 1'b0;
    short_d   = 1'b0;
    overrun_d = overrun_q;
    tally_inc = 1'b0;

    if (valid_q && result_ready) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (button) begin
          state_d = ROLLING;
          press_d = 8'd1;
        end
      end
      ROLLING: begin
        if (button) begin
          if (press_q < PRESS_MAX) press_d = press_q + 8'd1;
        end else begin
          state_d = IDLE;
          press_d = 8'd0;
          if (press_q < PRESS_MAX) begin
            short_d = 1'b1;
          end else if (!face_legal(throw)) begin
            illegal_d = 1'b1;
          end else if (!valid_q || result_ready) begin
            // A slot drained on this same edge can take the new value.
            result_d  = throw;
            valid_d   = 1'b1;
            tally_inc = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      press_q   <= 8'd0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      short_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      short_q   <= short_d;
      overrun_q <= overrun_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign illegal      = illegal_q;
  assign short_press  = short_q;
  assign overrun      = overrun_q;

`ifdef DICE_TALLY_EN
  dice_face_tally #(
    .TALLY_W (TALLY_W)
  ) u_tally (
    .clk   (clk),
    .rst   (rst),
    .inc   (tally_inc),
    .face  (throw),
    .sel   (tally_sel),
    .count (tally_count)
  );
`else
  logic unused_tally;
  assign unused_tally = ^{tally_sel, tally_inc};
  assign tally_count  = '0;
`endif

endmodule

// File: tb/tb_dice_capture.sv
// Directed bench for dice_capture: handshake, short/illegal pulses, overrun, reset abort, tallies.
module tb_dice_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [2:0] throw;
  logic [2:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       illegal;
  logic       short_press;
  logic       overrun;
  logic [2:0] tally_sel;
  logic [1:0] tally_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dice_capture #(
    .MIN_PRESS (4),
    .TALLY_W   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .throw        (throw),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .illegal      (illegal),
    .short_press  (short_press),
    .overrun      (overrun),
    .tally_sel    (tally_sel),
    .tally_count  (tally_count)
  );

  // Starts at a negedge, holds button n cycles, releases with face t and ready rdy,
  // returns at the negedge after the release edge (outputs visible).
  task automatic roll(input int n, input logic [2:0] t, input logic rdy);
    for (int i = 0; i < n; i++) begin
      button = 1'b1;
      @(negedge clk);
    end
    button       = 1'b0;
    throw        = t;
    result_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    button       = 1'b0;
    throw        = 3'd0;
    result_ready = 1'b0;
    tally_sel    = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({result, result_valid, illegal, short_press, overrun} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 0000000",
               {result, result_valid, illegal, short_press, overrun});
    end
    checks++;
    if (tally_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_tally: got %0d, expected 0", tally_count);
    end
  endtask

  task automatic test_accept_hold();
    roll(6, 3'd4, 1'b0);
    checks++;
    if (result !== 3'd4 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL accept_load: got result=%0d valid=%b, expected 4/1", result, result_valid);
    end
    @(negedge clk);
    checks++;
    if (result !== 3'd4 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL accept_hold: got result=%0d valid=%b, expected 4/1", result, result_valid);
    end
    result_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_consume: got valid=%b, expected 0", result_valid);
    end
    result_ready = 1'b0;
  endtask

  task automatic test_short_press();
    roll(2, 3'd3, 1'b0);
    checks++;
    if (short_press !== 1'b1 || result_valid !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL short_pulse: got short=%b valid=%b illegal=%b, expected 1/0/0",
               short_press, result_valid, illegal);
    end
    @(negedge clk);
    checks++;
    if (short_press !== 1'b0) begin
      errors++;
      $display("FAIL short_one_cycle: got short=%b, expected 0", short_press);
    end
    // Short press outranks an illegal face.
    roll(2, 3'd7, 1'b0);
    checks++;
    if (short_press !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL short_priority: got short=%b illegal=%b, expected 1/0", short_press, illegal);
    end
    roll(3, 3'd1, 1'b0);
    checks++;
    if (short_press !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_boundary3: got short=%b valid=%b, expected 1/0", short_press, result_valid);
    end
    roll(4, 3'd1, 1'b0);
    checks++;
    if (short_press !== 1'b0 || result_valid !== 1'b1 || result !== 3'd1) begin
      errors++;
      $display("FAIL press_boundary4: got short=%b valid=%b result=%0d, expected 0/1/1",
               short_press, result_valid, result);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_illegal();
    roll(5, 3'd7, 1'b0);
    checks++;
    if (illegal !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal7: got illegal=%b valid=%b, expected 1/0", illegal, result_valid);
    end
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_one_cycle: got illegal=%b, expected 0", illegal);
    end
    roll(5, 3'd0, 1'b0);
    checks++;
    if (illegal !== 1'b1 || result_valid !== 1'b0 || short_press !== 1'b0) begin
      errors++;
      $display("FAIL illegal0: got illegal=%b valid=%b short=%b, expected 1/0/0",
               illegal, result_valid, short_press);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    roll(5, 3'd2, 1'b0);
    roll(5, 3'd5, 1'b0);
    checks++;
    if (overrun !== 1'b1 || result !== 3'd2 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got overrun=%b result=%0d valid=%b, expected 1/2/1",
               overrun, result, result_valid);
    end
    result_ready = 1'b1;
    repeat (2) @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if (overrun !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_sticky: got overrun=%b valid=%b, expected 1/0", overrun, result_valid);
    end
    do_reset();
    roll(5, 3'd2, 1'b0);
    roll(5, 3'd5, 1'b1);
    checks++;
    if (overrun !== 1'b0 || result !== 3'd5 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_reload: got overrun=%b result=%0d valid=%b, expected 0/5/1",
               overrun, result, result_valid);
    end
    result_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (result !== 3'd5 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL reload_hold: got result=%0d valid=%b, expected 5/1", result, result_valid);
    end
  endtask

  task automatic test_reset_mid_roll();
    button = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    button = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({result, result_valid, illegal, short_press, overrun} !== 7'd0) begin
        errors++;
        $display("FAIL mid_roll_reset[%0d]: got %b, expected 0000000", i,
                 {result, result_valid, illegal, short_press, overrun});
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    result_ready = 1'b1;
    roll(4, 3'd3, 1'b1);
    checks++;
    if (result !== 3'd3 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got result=%0d valid=%b, expected 3/1", result, result_valid);
    end
    roll(4, 3'd6, 1'b1);
    checks++;
    if (result !== 3'd6 || result_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got result=%0d valid=%b overrun=%b, expected 6/1/0",
               result, result_valid, overrun);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got valid=%b, expected 0", result_valid);
    end
    result_ready = 1'b0;
  endtask

  task automatic test_tally();
    do_reset();
    result_ready = 1'b1;
    for (int i = 0; i < 5; i++) roll(4, 3'd6, 1'b1);
    roll(4, 3'd2, 1'b1);
    result_ready = 1'b0;
    tally_sel = 3'd6;
    #1;
`ifdef DICE_TALLY_EN
    checks++;
    if (tally_count !== 2'd3) begin
      errors++;
      $display("FAIL tally6_saturate: got %0d, expected 3", tally_count);
    end
    tally_sel = 3'd2;
    #1;
    checks++;
    if (tally_count !== 2'd1) begin
      errors++;
      $display("FAIL tally2: got %0d, expected 1", tally_count);
    end
`else
    checks++;
    if (tally_count !== 2'd0) begin
      errors++;
      $display("FAIL tally_disabled: got %0d, expected 0", tally_count);
    end
`endif
    tally_sel = 3'd7;
    #1;
    checks++;
    if (tally_count !== 2'd0) begin
      errors++;
      $display("FAIL tally_sel7: got %0d, expected 0", tally_count);
    end
    tally_sel = 3'd0;
    #1;
    checks++;
    if (tally_count !== 2'd0) begin
      errors++;
      $display("FAIL tally_sel0: got %0d, expected 0", tally_count);
    end
  endtask

  initial begin
    test_reset();
    test_accept_hold();
    test_short_press();
    test_illegal();
    test_overrun();
    test_reset_mid_roll();
    test_back_to_back();
    test_tally();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
